// File: rtl/core_step_pkg.sv
// Shared step numbering and sequencer state encoding for the 4-step core datapath.
package core_step_pkg;

    localparam int unsigned STEP_W = 2;

    localparam logic [STEP_W-1:0] STEP_FETCH     = 2'd0;
    localparam logic [STEP_W-1:0] STEP_DECODE    = 2'd1;
    localparam logic [STEP_W-1:0] STEP_EXECUTE   = 2'd2;
    localparam logic [STEP_W-1:0] STEP_WRITEBACK = 2'd3;

    typedef enum logic [1:0] {
        SEQ_RUN    = 2'd0,
        SEQ_WAIT   = 2'd1,
        SEQ_HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/wait_timer.sv
// Saturating count of consecutive stalled edges; expired flags the edge that would reach LIMIT.
module wait_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic inc,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_bumped;
    logic [CW-1:0] cnt_next;

    // Value the counter would take this edge, ignoring clear (keeps expired free of the clear path).
    always_comb begin
        cnt_bumped = cnt;
        if (start) begin
            cnt_bumped = CW'(1);
        end else if (inc && (cnt != CMAX)) begin
            cnt_bumped = cnt + CW'(1);
        end
    end

    always_comb begin
        cnt_next = cnt_bumped;
        if (clear) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign expired = (LIMIT != 0) && (start || inc) && (32'(cnt_bumped) == LIMIT);

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: walks fetch/decode/execute/writeback, stalls on memory wait,
// supports run/halt and single-instruction stepping, and times out stuck waits.
module step_sequencer
    import core_step_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned WAIT_LIMIT   = 8,
    parameter bit          START_HALTED = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   single_step,
    input  logic                   mem_request,
    input  logic                   mem_ready,
    output logic [1:0]             current_step,
    output logic                   step_advance,
    output logic                   instruction_done,
    output logic                   halted,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] instruction_count
);

    localparam seq_state_t RESET_STATE = START_HALTED ? SEQ_HALTED : SEQ_RUN;

    seq_state_t             state, state_next;
    logic [STEP_W-1:0]      step_next;
    logic                   bus_error_next;
    logic                   one_shot, one_shot_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   stall;
    logic                   tmr_start, tmr_inc, tmr_clear, tmr_expired;

    assign stall            = mem_request & ~mem_ready;
    assign step_advance     = (state != SEQ_HALTED) & ~stall;
    assign instruction_done = step_advance & (current_step == STEP_WRITEBACK);
    assign halted           = (state == SEQ_HALTED);

    wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (tmr_start),
        .inc     (tmr_inc),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= RESET_STATE;
            current_step      <= STEP_FETCH;
            bus_error         <= 1'b0;
            one_shot          <= 1'b0;
            instruction_count <= '0;
        end else begin
            state             <= state_next;
            current_step      <= step_next;
            bus_error         <= bus_error_next;
            one_shot          <= one_shot_next;
            instruction_count <= count_next;
        end
    end

    always_comb begin
        state_next     = state;
        step_next      = current_step;
        bus_error_next = bus_error;
        one_shot_next  = one_shot;
        count_next     = instruction_count;
        tmr_start      = 1'b0;
        tmr_inc        = 1'b0;
        tmr_clear      = 1'b0;

        unique case (state)
            SEQ_RUN, SEQ_WAIT: begin
                if (stall) begin
                    tmr_start = (state == SEQ_RUN);
                    tmr_inc   = (state == SEQ_WAIT);
                    // Timeout abandons the instruction uncounted; bus_error locks the core halted.
                    if (tmr_expired) begin
                        state_next     = SEQ_HALTED;
                        step_next      = STEP_FETCH;
                        bus_error_next = 1'b1;
                        one_shot_next  = 1'b0;
                        tmr_clear      = 1'b1;
                    end else begin
                        state_next = SEQ_WAIT;
                    end
                end else begin
                    tmr_clear  = 1'b1;
                    step_next  = current_step + STEP_W'(1);
                    state_next = SEQ_RUN;
                    if (current_step == STEP_WRITEBACK) begin
                        count_next    = instruction_count + COUNT_WIDTH'(1);
                        one_shot_next = 1'b0;
                        if (!run || one_shot) begin
                            state_next = SEQ_HALTED;
                        end
                    end
                end
            end
            SEQ_HALTED: begin
                step_next = STEP_FETCH;
                if (!bus_error) begin
                    if (run) begin
                        state_next = SEQ_RUN;
                    end else if (single_step) begin
                        state_next    = SEQ_RUN;
                        one_shot_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = SEQ_HALTED;
                step_next  = STEP_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: free run, memory wait, timeout, boundary halt,
// single step and asynchronous reset, with hand-computed expectations.
module tb_step_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        run, single_step, mem_request, mem_ready;
    logic [1:0]  current_step;
    logic        step_advance, instruction_done, halted, bus_error;
    logic [15:0] instruction_count;

    logic        run_b, single_step_b, mem_request_b, mem_ready_b;
    logic [1:0]  current_step_b;
    logic        step_advance_b, instruction_done_b, halted_b, bus_error_b;
    logic [15:0] instruction_count_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    step_sequencer #(.COUNT_WIDTH(16), .WAIT_LIMIT(4), .START_HALTED(1'b0)) dut_a (
        .clock             (clock),
        .reset_n           (reset_n),
        .run               (run),
        .single_step       (single_step),
        .mem_request       (mem_request),
        .mem_ready         (mem_ready),
        .current_step      (current_step),
        .step_advance      (step_advance),
        .instruction_done  (instruction_done),
        .halted            (halted),
        .bus_error         (bus_error),
        .instruction_count (instruction_count)
    );

    step_sequencer #(.COUNT_WIDTH(16), .WAIT_LIMIT(8), .START_HALTED(1'b1)) dut_b (
        .clock             (clock),
        .reset_n           (reset_n),
        .run               (run_b),
        .single_step       (single_step_b),
        .mem_request       (mem_request_b),
        .mem_ready         (mem_ready_b),
        .current_step      (current_step_b),
        .step_advance      (step_advance_b),
        .instruction_done  (instruction_done_b),
        .halted            (halted_b),
        .bus_error         (bus_error_b),
        .instruction_count (instruction_count_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        run           = 1'b1;
        single_step   = 1'b0;
        mem_request   = 1'b0;
        mem_ready     = 1'b0;
        run_b         = 1'b0;
        single_step_b = 1'b0;
        mem_request_b = 1'b0;
        mem_ready_b   = 1'b0;

        #12;
        check_eq("rst_step", 32'(current_step), 32'd0);
        check_eq("rst_count", 32'(instruction_count), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_bus_error", 32'(bus_error), 32'd0);
        check_eq("rst_b_halted", 32'(halted_b), 32'd1);
        check_eq("rst_b_step", 32'(current_step_b), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Free run: 12 edges, mem_ready toggled on without mem_request halfway through
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("free_step", 32'(current_step), 32'((i + 1) % 4));
            check_eq("free_done", 32'(instruction_done), 32'(((i + 1) % 4) == 3));
            mem_ready = (i >= 5);
        end
        check_eq("free_count", 32'(instruction_count), 32'd3);

        // Memory wait on step 1 for 3 edges
        mem_ready = 1'b0;
        tick();
        check_eq("wait_pre_step", 32'(current_step), 32'd1);
        mem_request = 1'b1;
        #1;
        check_eq("wait_adv_low", 32'(step_advance), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("wait_hold_step", 32'(current_step), 32'd1);
            check_eq("wait_hold_adv", 32'(step_advance), 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        check_eq("wait_ready_adv", 32'(step_advance), 32'd1);
        tick();
        check_eq("wait_post_step", 32'(current_step), 32'd2);
        check_eq("wait_bus_error", 32'(bus_error), 32'd0);
        check_eq("wait_halted", 32'(halted), 32'd0);
        check_eq("wait_count", 32'(instruction_count), 32'd3);
        mem_request = 1'b0;
        mem_ready   = 1'b0;

        // Asynchronous reset mid-step 2, no clock edge involved
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("areset_step", 32'(current_step), 32'd0);
        check_eq("areset_count", 32'(instruction_count), 32'd0);
        check_eq("areset_bus_error", 32'(bus_error), 32'd0);
        #2;
        reset_n = 1'b1;

        // Timeout: retire one instruction, then stall at step 2 with WAIT_LIMIT=4
        for (int k = 0; k < 6; k++) tick();
        check_eq("to_pre_step", 32'(current_step), 32'd2);
        check_eq("to_pre_count", 32'(instruction_count), 32'd1);
        mem_request = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("to_stall_step", 32'(current_step), 32'd2);
            check_eq("to_stall_halted", 32'(halted), 32'd0);
        end
        tick();
        check_eq("to_halted", 32'(halted), 32'd1);
        check_eq("to_bus_error", 32'(bus_error), 32'd1);
        check_eq("to_step", 32'(current_step), 32'd0);
        check_eq("to_count", 32'(instruction_count), 32'd1);
        mem_request = 1'b0;
        run         = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("to_sticky_halted", 32'(halted), 32'd1);
            check_eq("to_sticky_bus", 32'(bus_error), 32'd1);
            check_eq("to_sticky_adv", 32'(step_advance), 32'd0);
        end

        // Reset clears the sticky error asynchronously
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("areset2_bus_error", 32'(bus_error), 32'd0);
        check_eq("areset2_halted", 32'(halted), 32'd0);
        #2;
        reset_n = 1'b1;

        // Halt at boundary: run drops on step 1, stall on step 3 before completing
        tick();
        check_eq("hb_step1", 32'(current_step), 32'd1);
        run = 1'b0;
        tick();
        check_eq("hb_step2", 32'(current_step), 32'd2);
        tick();
        check_eq("hb_step3", 32'(current_step), 32'd3);
        check_eq("hb_not_halted", 32'(halted), 32'd0);
        mem_request = 1'b1;
        #1;
        check_eq("hb_stall_done", 32'(instruction_done), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("hb_stall_step", 32'(current_step), 32'd3);
            check_eq("hb_stall_halted", 32'(halted), 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        check_eq("hb_ready_done", 32'(instruction_done), 32'd1);
        tick();
        check_eq("hb_halted", 32'(halted), 32'd1);
        check_eq("hb_step0", 32'(current_step), 32'd0);
        check_eq("hb_count", 32'(instruction_count), 32'd1);
        mem_request = 1'b0;
        mem_ready   = 1'b0;
        tick();
        check_eq("hb_still_halted", 32'(halted), 32'd1);
        check_eq("hb_halt_adv", 32'(step_advance), 32'd0);
        run = 1'b1;
        tick();
        check_eq("hb_resume_halted", 32'(halted), 32'd0);
        check_eq("hb_resume_step", 32'(current_step), 32'd0);
        tick();
        check_eq("hb_first_adv", 32'(current_step), 32'd1);

        // Single step on the START_HALTED instance
        check_eq("ss_pre_halted", 32'(halted_b), 32'd1);
        single_step_b = 1'b1;
        tick();
        check_eq("ss_go_halted", 32'(halted_b), 32'd0);
        check_eq("ss_go_step", 32'(current_step_b), 32'd0);
        single_step_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_eq("ss_adv", 32'(step_advance_b), 32'd1);
            tick();
            check_eq("ss_step", 32'(current_step_b), 32'(k % 4));
        end
        check_eq("ss_halted", 32'(halted_b), 32'd1);
        check_eq("ss_count", 32'(instruction_count_b), 32'd1);
        tick();
        check_eq("ss_hold_halted", 32'(halted_b), 32'd1);
        check_eq("ss_hold_step", 32'(current_step_b), 32'd0);
        check_eq("ss_hold_count", 32'(instruction_count_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
